bitstream_dequota: RTL and testbench

//  Stochastic-bitstream decoder: inverse of the quota encoder.
//  - Accepts a serial unipolar bitstream, one bit per handshake; counts ones over a window of BITSTREAM bits.
//  - Rebuilds the signed QUANT-bit value the window represents.
//  - Sits at the output of the stochastic datapath and returns results to the binary (fixed-point) domain.

---
 rtl/dequota_pkg.sv | 26 ++
 rtl/dequota_win_cnt.sv | 58 +++++
 rtl/bitstream_dequota.sv | 95 +++++++++
 tb/tb_bitstream_dequota.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dequota_pkg.sv
// Shared types and width helpers for the stochastic-bitstream decoder.
package dequota_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic int pos_w(input int bitstream);
    return $clog2(bitstream);
  endfunction

  // One extra bit so a window of all ones (count == BITSTREAM) is representable.
  function automatic int cnt_w(input int bitstream);
    return $clog2(bitstream) + 1;
  endfunction

  function automatic int shift_of(input int quant, input int bitstream);
    return quant - $clog2(bitstream);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/dequota_win_cnt.sv
// Window position and ones counter; flags the accepted last bit of each window
// and exposes the final count including that bit.
module dequota_win_cnt
  import dequota_pkg::*;
#(
  parameter  int BITSTREAM = 64,
  localparam int PW        = pos_w(BITSTREAM),
  localparam int CW        = cnt_w(BITSTREAM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          accept,
  input  logic          bit_in,
  output logic [PW-1:0] win_pos,
  output logic [CW-1:0] cnt_f,
  output logic          last
);

  localparam logic [PW-1:0] LAST_POS = PW'(BITSTREAM - 1);

  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_f   = cnt_q + CW'(bit_in);
  assign last    = accept && !clr && (pos_q == LAST_POS);
  assign win_pos = pos_q;

  // NOTE: every next-state variable gets a default first, so no latch is inferred.
  always_comb begin
    pos_d = pos_q;
    cnt_d = cnt_q;
    if (clr) begin
      pos_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (pos_q == LAST_POS) begin
        pos_d = '0;
        cnt_d = '0;
      end else begin
        pos_d = pos_q + PW'(1);
        cnt_d = cnt_f;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bitstream_dequota.sv
// Stochastic unipolar bitstream -> signed QUANT-bit value, one result per window.
// Define DEQUOTA_SAT_EN to clamp the all-ones window to the positive maximum.
module bitstream_dequota
  import dequota_pkg::*;
#(
  parameter  int BITSTREAM = 64,
  parameter  int QUANT     = 8,
  localparam int PW        = pos_w(BITSTREAM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    bit_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [QUANT-1:0] data_out,
  output logic                    out_sat,
  output logic [PW-1:0]           win_pos
);

  localparam int CW = cnt_w(BITSTREAM);
  localparam int SH = shift_of(QUANT, BITSTREAM);
  localparam logic [PW-1:0]  LAST_POS = PW'(BITSTREAM - 1);
  localparam logic [QUANT:0] HALF     = {2'b01, {(QUANT-1){1'b0}}};

  if (BITSTREAM < 2 || !is_pow2(BITSTREAM)) begin : g_bs_check
    $error("bitstream_dequota: BITSTREAM must be a power of two");
  end
  if (QUANT < PW) begin : g_quant_check
    $error("bitstream_dequota: QUANT must be >= $clog2(BITSTREAM)");
  end

  logic          accept;
  logic          last;
  logic [CW-1:0] cnt_f;
  logic [QUANT:0] res_w;
  logic [QUANT-1:0] res_val;
  logic          res_sat;

  slot_state_t      state_q;
  logic [QUANT-1:0] data_q;
  logic             sat_q;

  // Only the closing bit must wait for the output slot; earlier bits never do.
  assign in_ready = !((win_pos == LAST_POS) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready && !clr;

  dequota_win_cnt #(.BITSTREAM(BITSTREAM)) u_win_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .accept  (accept),
    .bit_in  (bit_in),
    .win_pos (win_pos),
    .cnt_f   (cnt_f),
    .last    (last)
  );

  // Offset-binary to two's complement: scale the count, then remove the midpoint.
  assign res_w = ((QUANT+1)'(cnt_f) << SH) - HALF;

`ifdef DEQUOTA_SAT_EN
  logic ovf;
  assign ovf     = res_w[QUANT] != res_w[QUANT-1];
  assign res_val = ovf ? {1'b0, {(QUANT-1){1'b1}}} : res_w[QUANT-1:0];
  assign res_sat = ovf;
`else
  logic unused_msb;
  assign unused_msb = res_w[QUANT];
  assign res_val    = res_w[QUANT-1:0];
  assign res_sat    = 1'b0;
`endif

  // A completion in the same cycle as a pop reloads the slot instead of emptying it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else if (last) begin
      state_q <= SLOT_FULL;
      data_q  <= res_val;
      sat_q   <= res_sat;
    end else if (state_q == SLOT_FULL && out_ready) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign data_out  = data_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_bitstream_dequota.sv
// Self-checking bench for bitstream_dequota (BITSTREAM=64, QUANT=8) against a
// count-of-ones reference model.
module tb_bitstream_dequota;

  localparam int BS = 64;
  localparam int Q  = 8;
  localparam int SH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              bit_in = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] data_out;
  logic              out_sat;
  logic [5:0]        win_pos;

  int checks = 0;
  int errors = 0;

  bitstream_dequota #(.BITSTREAM(BS), .QUANT(Q)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bit_in    (bit_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_sat   (out_sat),
    .win_pos   (win_pos)
  );

  always #5 clk = ~clk;

  // Reference model: a window with k ones represents k/BS of full scale, mapped to signed range.
  function automatic logic signed [7:0] exp_val(input int ones);
    int v;
    v = ones * (1 << SH) - (1 << (Q - 1));
`ifdef DEQUOTA_SAT_EN
    if (v > (1 << (Q - 1)) - 1) v = (1 << (Q - 1)) - 1;
`endif
    return 8'(v);
  endfunction

  function automatic logic exp_sat(input int ones);
`ifdef DEQUOTA_SAT_EN
    return ones == BS;
`else
    return (ones < 0);
`endif
  endfunction

  function automatic logic [63:0] make_window(input int ones);
    logic [63:0] w;
    logic t;
    int j;
    w = '0;
    for (int i = 0; i < ones; i++) w[i] = 1'b1;
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = w[i]; w[i] = w[j]; w[j] = t;
    end
    return w;
  endfunction

  // Present one bit; returns at posedge+1 after it was accepted.
  task automatic push_bit(input logic b, output int stalls);
    in_valid = 1'b1;
    bit_in   = b;
    stalls   = 0;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_range(input logic [63:0] w, input int from, input int to, output int stalls);
    int s;
    stalls = 0;
    for (int i = from; i <= to; i++) begin
      push_bit(w[i], s);
      stalls += s;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (data_out !== 8'sd0) begin errors++; $display("FAIL rst_data_out: got %0d required 0", data_out); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat: got %0b required 0", out_sat); end
    checks++; if (win_pos !== 6'd0) begin errors++; $display("FAIL rst_win_pos: got %0d required 0", win_pos); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_half();
    logic [63:0] w;
    int s;
    out_ready = 1'b1;
    w = make_window(32);
    push_range(w, 0, 62, s);
    checks++; if (win_pos !== 6'd63) begin errors++; $display("FAIL half_pos63: got %0d required 63", win_pos); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL half_early_valid: got %0b required 0", out_valid); end
    push_bit(w[63], s);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL half_valid: got %0b required 1", out_valid); end
    checks++; if (data_out !== exp_val(32)) begin errors++; $display("FAIL half_data: got %0d required %0d", data_out, exp_val(32)); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL half_sat: got %0b required 0", out_sat); end
    checks++; if (win_pos !== 6'd0) begin errors++; $display("FAIL half_wrap: got %0d required 0", win_pos); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL half_pop: got %0b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w0, w1;
    int s0, s1;
    longint t0;
    out_ready = 1'b1;
    w0 = make_window(0);
    w1 = make_window(33);
    t0 = $time;
    push_range(w0, 0, 63, s0);
    checks++; if (data_out !== exp_val(0)) begin errors++; $display("FAIL b2b_zero: got %0d required %0d", data_out, exp_val(0)); end
    push_range(w1, 0, 63, s1);
    checks++; if (data_out !== exp_val(33) || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_33: got %0d/%0b required %0d/1", data_out, out_valid, exp_val(33)); end
    checks++; if (s0 + s1 != 0) begin errors++; $display("FAIL b2b_stalls: got %0d required 0", s0 + s1); end
    checks++; if ($time - t0 != 128 * 10) begin errors++; $display("FAIL b2b_cycles: got %0d required %0d", ($time - t0) / 10, 128); end
    drain();
  endtask

  task automatic test_full_window();
    logic [63:0] w;
    int s;
    out_ready = 1'b1;
    w = make_window(64);
    push_range(w, 0, 63, s);
    checks++; if (data_out !== exp_val(64)) begin errors++; $display("FAIL full_data: got %0d required %0d", data_out, exp_val(64)); end
    checks++; if (out_sat !== exp_sat(64)) begin errors++; $display("FAIL full_sat: got %0b required %0b", out_sat, exp_sat(64)); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] wa, wb;
    int s;
    out_ready = 1'b0;
    wa = make_window(20);
    wb = make_window(50);
    push_range(wa, 0, 63, s);
    checks++; if (out_valid !== 1'b1 || data_out !== exp_val(20)) begin errors++; $display("FAIL bp_first: got %0d/%0b required %0d/1", data_out, out_valid, exp_val(20)); end
    push_range(wb, 0, 62, s);
    checks++; if (s != 0) begin errors++; $display("FAIL bp_mid_stalls: got %0d required 0", s); end
    in_valid = 1'b1;
    bit_in   = wb[63];
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got %0b required 0", in_ready); end
    checks++; if (win_pos !== 6'd63) begin errors++; $display("FAIL bp_pos: got %0d required 63", win_pos); end
    @(posedge clk); #1;
    checks++; if (data_out !== exp_val(20) || win_pos !== 6'd63) begin errors++; $display("FAIL bp_hold: got %0d/%0d required %0d/63", data_out, win_pos, exp_val(20)); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || data_out !== exp_val(50)) begin errors++; $display("FAIL bp_second: got %0d/%0b required %0d/1", data_out, out_valid, exp_val(50)); end
    checks++; if (win_pos !== 6'd0) begin errors++; $display("FAIL bp_wrap: got %0d required 0", win_pos); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b required 0", out_valid); end
  endtask

  task automatic test_clr();
    logic [63:0] wp, wx, wd;
    int s;
    out_ready = 1'b0;
    wp = make_window(40);
    wx = make_window(30);
    wd = make_window(16);
    push_range(wp, 0, 63, s);
    push_range(wx, 0, 39, s);
    checks++; if (win_pos !== 6'd40) begin errors++; $display("FAIL clr_pos40: got %0d required 40", win_pos); end
    clr = 1'b1; in_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (win_pos !== 6'd0) begin errors++; $display("FAIL clr_pos0: got %0d required 0", win_pos); end
    checks++; if (out_valid !== 1'b1 || data_out !== exp_val(40)) begin errors++; $display("FAIL clr_slot: got %0d/%0b required %0d/1", data_out, out_valid, exp_val(40)); end
    push_range(wd, 0, 62, s);
    checks++; if (data_out !== exp_val(40)) begin errors++; $display("FAIL clr_pending: got %0d required %0d", data_out, exp_val(40)); end
    out_ready = 1'b1;
    push_bit(wd[63], s);
    checks++; if (out_valid !== 1'b1 || data_out !== exp_val(16)) begin errors++; $display("FAIL clr_result: got %0d/%0b required %0d/1", data_out, out_valid, exp_val(16)); end
    drain();
  endtask

  task automatic test_random();
    int exp_q[$];
    bit done;
    int pops;
    int cyc;
    done = 1'b0;
    pops = 0;
    cyc  = 0;
    fork
      begin
        logic [63:0] w;
        int ones, s;
        for (int k = 0; k < 8; k++) begin
          ones = (k == 0) ? 64 : (k == 1) ? 0 : int'($urandom_range(64, 0));
          w = make_window(ones);
          for (int i = 0; i < 64; i++) begin
            if ($urandom_range(3, 0) == 0) begin
              @(posedge clk); #1;
            end
            push_bit(w[i], s);
          end
          exp_q.push_back(ones);
        end
        done = 1'b1;
      end
      begin
        int ones;
        while (!(done && exp_q.size() == 0) && cyc < 20000) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1, 0));
          @(negedge clk);
          if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL rnd_extra: got %0d with nothing expected", data_out);
            end else begin
              ones = exp_q.pop_front();
              pops++;
              if (data_out !== exp_val(ones) || out_sat !== exp_sat(ones)) begin
                errors++; $display("FAIL rnd_value: got %0d/%0b required %0d/%0b (ones=%0d)", data_out, out_sat, exp_val(ones), exp_sat(ones), ones);
              end
            end
          end
          cyc++;
        end
      end
    join
    checks++; if (pops != 8) begin errors++; $display("FAIL rnd_count: got %0d required 8", pops); end
    drain();
  endtask

  task automatic test_async_reset();
    logic [63:0] w;
    int s;
    out_ready = 1'b0;
    w = make_window(10);
    push_range(w, 0, 63, s);
    push_range(w, 0, 19, s);
    checks++; if (win_pos !== 6'd20 || out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0d/%0b required 20/1", win_pos, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b required 0", out_valid); end
    checks++; if (data_out !== 8'sd0) begin errors++; $display("FAIL arst_data: got %0d required 0", data_out); end
    checks++; if (win_pos !== 6'd0) begin errors++; $display("FAIL arst_pos: got %0d required 0", win_pos); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_after: got %0b/%0b required 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_half();
    test_back_to_back();
    test_full_window();
    test_backpressure();
    test_clr();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
